// File: rtl/pipe_defs.sv
// Shared pipeline-control definitions: stall bus layout, stall patterns and
// divider sequencer state encodings.
package pipe_defs;

    typedef logic [5:0] StallBus;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam int STG_PC    = 0;
    localparam int STG_IFID  = 1;
    localparam int STG_IDEX  = 2;
    localparam int STG_EXMEM = 3;
    localparam int STG_WB    = 4;
    localparam int STG_RSVD  = 5;

    localparam StallBus STALL_NONE  = 6'b000000;
    localparam StallBus STALL_LDUSE = 6'b000111;
    localparam StallBus STALL_EXMC  = 6'b001111;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // A source operand conflicts when it is actually read and names the register.
    function automatic logic reg_match(input logic use_src, input logic [4:0] src,
                                       input logic [4:0] dst);
        return use_src && (src == dst);
    endfunction

endpackage

// File: rtl/div_seq.sv
// Iterative divider sequencer: IDLE -> RUN for DIV_CYCLES steps -> DONE pulse.
module div_seq
    import pipe_defs::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic step,
    output logic done,
    output logic busy
);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    // Starts seen in RUN or DONE are dropped: EX has already moved on.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= RUN;
                    cnt   <= CNT_W'(DIV_CYCLES - 1);
                end
                RUN: begin
                    if (cnt == '0) state <= DONE;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign step = (state == RUN);
    assign done = (state == DONE);
    assign busy = (state != IDLE);

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall arbiter: load-use hazard detection plus divider sequencing,
// producing one StallBus for all pipeline registers.
module stall_ctrl
    import pipe_defs::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       ex_is_load,
    input  logic [4:0] ex_rf_waddr,
    input  logic       ex_div_start,
    output logic       div_step,
    output logic       div_done,
    output StallBus    stall,
    output logic       busy
);

    logic ld_hz;
    logic div_stall;

    div_seq #(
        .DIV_CYCLES(DIV_CYCLES),
        .CNT_W     (CNT_W)
    ) u_div_seq (
        .clk  (clk),
        .rst  (rst),
        .start(ex_div_start),
        .step (div_step),
        .done (div_done),
        .busy (busy)
    );

    assign ld_hz = ex_is_load && (ex_rf_waddr != 5'd0) &&
                   (reg_match(id_use_rs, id_rs, ex_rf_waddr) ||
                    reg_match(id_use_rt, id_rt, ex_rf_waddr));

    // Start cycle counts as stalled too; DONE releases so the divide retires.
    assign div_stall = (!busy && ex_div_start) || div_step;

    always_comb begin
        stall = STALL_NONE;
        if (div_stall)  stall = STALL_EXMC;
        else if (ld_hz) stall = STALL_LDUSE;
    end

endmodule

// File: tb/tb_stall_ctrl.sv
// Scoreboard bench for stall_ctrl: default-size and 2-cycle divider instances,
// directed vectors with hand-computed per-cycle expectations.
module tb_stall_ctrl;
    import pipe_defs::*;

    typedef struct packed {
        StallBus stall;
        logic    step;
        logic    done;
        logic    busy;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rf_waddr;
    logic       id_use_rs, id_use_rt, ex_is_load;
    logic       a_start, b_start;
    logic       a_step, a_done, a_busy, b_step, b_done, b_busy;
    StallBus    a_stall, b_stall;

    int checks   = 0;
    int failures = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    stall_ctrl u_a (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_is_load(ex_is_load),
        .ex_rf_waddr(ex_rf_waddr), .ex_div_start(a_start),
        .div_step(a_step), .div_done(a_done), .stall(a_stall), .busy(a_busy)
    );

    stall_ctrl #(.DIV_CYCLES(2), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_is_load(ex_is_load),
        .ex_rf_waddr(ex_rf_waddr), .ex_div_start(b_start),
        .div_step(b_step), .div_done(b_done), .stall(b_stall), .busy(b_busy)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, req);
        end
    endtask

    function automatic exp_t mk(input StallBus s, input logic st, input logic d, input logic b);
        exp_t e;
        e.stall = s; e.step = st; e.done = d; e.busy = b;
        return e;
    endfunction

    // Outputs are valid every cycle; sample mid-cycle, away from the edge.
    always @(negedge clk) begin
        exp_t ea, eb;
        if (q_a.size() > 0) begin
            ea = q_a.pop_front();
            chk("a_stall", int'(a_stall), int'(ea.stall));
            chk("a_step",  int'(a_step),  int'(ea.step));
            chk("a_done",  int'(a_done),  int'(ea.done));
            chk("a_busy",  int'(a_busy),  int'(ea.busy));
        end
        if (q_b.size() > 0) begin
            eb = q_b.pop_front();
            chk("b_stall", int'(b_stall), int'(eb.stall));
            chk("b_step",  int'(b_step),  int'(eb.step));
            chk("b_done",  int'(b_done),  int'(eb.done));
            chk("b_busy",  int'(b_busy),  int'(eb.busy));
        end
    end

    task automatic cyc(input exp_t ea, input exp_t eb);
        q_a.push_back(ea);
        q_b.push_back(eb);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ld();
        id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        ex_is_load = 1'b0; ex_rf_waddr = 5'd0;
    endtask

    task automatic set_ld_rs5();
        ex_is_load = 1'b1; ex_rf_waddr = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
    endtask

    exp_t IDL, LDU, DSTART, DRUN, DDONE;

    initial begin
        IDL    = mk(STALL_NONE,  1'b0, 1'b0, 1'b0);
        LDU    = mk(STALL_LDUSE, 1'b0, 1'b0, 1'b0);
        DSTART = mk(STALL_EXMC,  1'b0, 1'b0, 1'b0);
        DRUN   = mk(STALL_EXMC,  1'b1, 1'b0, 1'b1);
        DDONE  = mk(STALL_NONE,  1'b0, 1'b1, 1'b1);

        rst = 1'b1; a_start = 1'b0; b_start = 1'b0;
        clear_ld();
        @(posedge clk); #1;

        // reset state; stall is still combinational in reset
        cyc(IDL, IDL);
        set_ld_rs5();
        cyc(LDU, LDU);
        clear_ld();
        rst = 1'b0;
        cyc(IDL, IDL);

        // load-use on rs, then load drops
        set_ld_rs5();
        cyc(LDU, LDU);
        ex_is_load = 1'b0;
        cyc(IDL, IDL);

        // load to $0 never hazards
        clear_ld();
        ex_is_load = 1'b1; ex_rf_waddr = 5'd0; id_rt = 5'd0; id_use_rt = 1'b1;
        id_rs = 5'd0; id_use_rs = 1'b1;
        cyc(IDL, IDL);

        // rt match, then same fields but rt unused
        clear_ld();
        ex_is_load = 1'b1; ex_rf_waddr = 5'd7; id_rt = 5'd7; id_use_rt = 1'b1; id_rs = 5'd3;
        id_use_rs = 1'b1;
        cyc(LDU, LDU);
        id_use_rt = 1'b0;
        cyc(IDL, IDL);
        clear_ld();

        // default divide: 33 stalled cycles, 32 steps, done in cycle 34
        a_start = 1'b1;
        cyc(DSTART, IDL);
        for (int i = 0; i < 32; i++) cyc(DRUN, IDL);
        a_start = 1'b0;
        cyc(DDONE, IDL);
        cyc(IDL, IDL);

        // short divide with start held into DONE, then back-to-back restart
        b_start = 1'b1;
        cyc(IDL, DSTART);
        cyc(IDL, DRUN);
        cyc(IDL, DRUN);
        cyc(IDL, DDONE);
        cyc(IDL, DSTART);
        cyc(IDL, DRUN);
        cyc(IDL, DRUN);
        b_start = 1'b0;
        cyc(IDL, DDONE);
        cyc(IDL, IDL);

        // reset during RUN cycle 10
        a_start = 1'b1;
        cyc(DSTART, IDL);
        for (int i = 1; i <= 9; i++) cyc(DRUN, IDL);
        rst = 1'b1;
        cyc(DRUN, IDL);
        rst = 1'b0; a_start = 1'b0;
        cyc(IDL, IDL);
        cyc(IDL, IDL);

        // divide start with a simultaneous load-use; ld_hz shows through in DONE
        set_ld_rs5();
        a_start = 1'b1;
        cyc(DSTART, LDU);
        for (int i = 0; i < 32; i++) cyc(DRUN, LDU);
        a_start = 1'b0;
        cyc(mk(STALL_LDUSE, 1'b0, 1'b1, 1'b1), LDU);
        clear_ld();
        cyc(IDL, IDL);

        chk("queue_drain", q_a.size() + q_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
